piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in serial-out serializer. It sits directly upstream of the 4-bit serial shift register and drives that register's serial input A.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per clock with a frame-start marker and a valid qualifier.
- Inserts a configurable idle gap between frames so the downstream register sees well-separated bit streams.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..16.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- GAP_CYCLES, 1, idle cycles inserted after each frame; legal range 0..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- clr  input  1  reset; synchronous, active-high.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din is presented for transfer.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data; connects to downstream A.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high only during the first bit of a frame.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: clr sampled high at a rising edge forces the following.
  - state = IDLE, shift register = 0, bit counter = 0, gap counter = 0.
  - sout = 0, sout_valid = 0, frame_start = 0, busy = 0.
  - din_ready is combinational: (state == IDLE) && !clr, so it is 0 while clr is high.
- States:
  - IDLE: din_ready = 1.
  - SHIFT: WIDTH cycles, or WIDTH+1 with parity enabled.
  - GAP: GAP_CYCLES cycles.
- Transfer: occurs at edge T when din_valid && din_ready.
  - din is loaded into the internal shift register and the bit counter is cleared.
  - state goes to SHIFT.
  - din_valid while din_ready = 0 is ignored; din is not captured.
- Output timing:
  - In the cycle after edge T+k (k = 0..WIDTH-1), sout = data bit k in send order and sout_valid = 1.
  - frame_start = 1 only for k = 0.
  - All outputs are registered; no combinational path from din to sout.
- Shift direction: the register shifts toward the output end each edge; vacated bits fill with 0.
- End of frame:
  - After the last bit, go to GAP with sout = 0 and sout_valid = 0 for GAP_CYCLES cycles, then go to IDLE.
  - With GAP_CYCLES = 0, go directly from SHIFT to IDLE.
- Throughput: minimum frame period is WIDTH + GAP_CYCLES + 1 cycles (6 at defaults).
  - The extra cycle is the IDLE/accept cycle.
  - There is no accept during the last SHIFT cycle.
- Counters:
  - Bit counter width is $clog2(WIDTH+2).
  - Gap counter is 4 bits.
  - Both counters clear on state entry and never wrap within a state.
- Reset mid-frame: the frame is aborted. The cycle after the clr edge shows all outputs at their reset values, and no partial bits are emitted later.
- Simultaneous clr and transfer: clr wins and the word is dropped. This is consistent because din_ready = 0 while clr is high.
- din changes after the transfer edge have no effect on the frame in flight.
- busy = 1 in SHIFT and GAP.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - One extra SHIFT cycle follows the last data bit, carrying even parity (XOR of all WIDTH data bits) on sout with sout_valid = 1 and frame_start = 0.
  - Frame length is WIDTH+1 and minimum period is WIDTH + GAP_CYCLES + 2.
  - Parity is computed from din at the transfer edge and stored.
- Not defined:
  - No parity bit; frame length is exactly WIDTH.
  - No parity storage register exists.

Test Plan:
- Reset: hold clr = 1 for 2 edges with din_valid = 1 -> sout = 0, sout_valid = 0, frame_start = 0, busy = 0, din_ready = 0. After clr drops, din_ready = 1 and nothing was captured.
- Single word, defaults: din = 4'b1011 accepted at edge T -> sout = 1,0,1,1 in cycles T+1..T+4, sout_valid = 1 and frame_start = 1 only in T+1, cycle T+5 gap (sout_valid = 0), din_ready = 1 in T+6.
- Streaming: din_valid held high with words 4'b0011 then 4'b1100 -> second frame_start exactly 6 cycles after the first. With MSB_FIRST = 0 and din = 4'b0011, sout = 1,1,0,0.
- Ignored input: din_valid pulsed with 4'b1111 during SHIFT of 4'b0000 -> sout stays 0 for all 4 bits, and no extra frame follows.
- Abort: clr = 1 at the edge after bit 1 of 4'b1010 -> all outputs 0 the next cycle. The next accepted word 4'b0110 emits cleanly as 0,1,1,0.
- Parity (macro defined): din = 4'b1011 -> sout = 1,0,1,1,1 with sout_valid high for 5 cycles. din = 4'b1001 -> trailing bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out serializer feeding the serial input
// of a downstream shift register. A word accepted over a valid/ready handshake
// is emitted one bit per clock with a frame-start marker and a valid qualifier.
// An idle gap of GAP_CYCLES follows each frame.
// Optional feature: define PISO_SERIALIZER_PARITY_EN to append an even-parity
// bit after the last data bit of every frame.

module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    localparam int CNT_W = $clog2(WIDTH + 2);

    // Index of the final bit of a frame (data or parity).
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
    // Index of the final data bit; the parity bit follows it.
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`endif

    // Gap counter value on the final idle cycle (unused when there is no gap).
    localparam logic [3:0] LAST_GAP = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bitCnt;
    logic [3:0]       r_gapCnt;
    logic             r_sout;
    logic             r_soutValid;
    logic             r_frameStart;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             r_parity;
`endif

    logic [WIDTH-1:0] w_shifted;
    logic             w_nextBit;
    logic             w_firstBit;

    assign din_ready   = (r_state == IDLE) && !clr;
    assign busy        = (r_state != IDLE);
    assign sout        = r_sout;
    assign sout_valid  = r_soutValid;
    assign frame_start = r_frameStart;

    // Shift toward the output end (zero fill) and pick the bit that lands there.
    always_comb begin
        w_shifted  = '0;
        w_nextBit  = 1'b0;
        w_firstBit = 1'b0;
        if (MSB_FIRST != 0) begin
            w_shifted  = {r_shift[WIDTH-2:0], 1'b0};
            w_nextBit  = w_shifted[WIDTH-1];
            w_firstBit = din[WIDTH-1];
        end else begin
            w_shifted  = {1'b0, r_shift[WIDTH-1:1]};
            w_nextBit  = w_shifted[0];
            w_firstBit = din[0];
        end
    end

    // Frame FSM: accept in IDLE, emit bits in SHIFT, hold outputs low in GAP.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bitCnt     <= '0;
            r_gapCnt     <= '0;
            r_sout       <= 1'b0;
            r_soutValid  <= 1'b0;
            r_frameStart <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_shift      <= din;
                        r_bitCnt     <= '0;
                        r_sout       <= w_firstBit;
                        r_soutValid  <= 1'b1;
                        r_frameStart <= 1'b1;
                        r_state      <= SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
                        r_parity     <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    r_frameStart <= 1'b0;
                    if (r_bitCnt == LAST_BIT) begin
                        r_sout      <= 1'b0;
                        r_soutValid <= 1'b0;
                        r_gapCnt    <= '0;
                        r_state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        r_shift  <= w_shifted;
                        r_bitCnt <= r_bitCnt + CNT_W'(1);
`ifdef PISO_SERIALIZER_PARITY_EN
                        if (r_bitCnt == DATA_LAST) begin
                            r_sout <= r_parity;
                        end else begin
                            r_sout <= w_nextBit;
                        end
`else
                        r_sout <= w_nextBit;
`endif
                    end
                end
                GAP: begin
                    if (r_gapCnt == LAST_GAP) begin
                        r_state <= IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 4'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives two serializer instances (MSB-first with a
// one-cycle gap, LSB-first with a three-cycle gap) from shared stimulus.
// A reference model queues the expected bit stream per instance on each
// accepted word; a monitor pops and compares whenever sout_valid is high and
// checks handshake/busy timing against the model's frame schedule.

module tb_piso_serializer;

    localparam int WIDTH = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int LANE_MSB[2] = '{1, 0};
    localparam int LANE_GAP[2] = '{1, 3};

    logic             clk;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic             dinValid;
    logic [1:0]       dinReady;
    logic [1:0]       sout;
    logic [1:0]       soutValid;
    logic [1:0]       frameStart;
    logic [1:0]       busy;

    int total = 0;
    int bad   = 0;

    int edgeCnt = 0;
    int freeAt[2];
    int lastT[2];
    bit [1:0] expQ[2][$];

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1), .GAP_CYCLES(1)) dutMsb (
        .clk        (clk),
        .clr        (clr),
        .din        (din),
        .din_valid  (dinValid),
        .din_ready  (dinReady[0]),
        .sout       (sout[0]),
        .sout_valid (soutValid[0]),
        .frame_start(frameStart[0]),
        .busy       (busy[0])
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0), .GAP_CYCLES(3)) dutLsb (
        .clk        (clk),
        .clr        (clr),
        .din        (din),
        .din_valid  (dinValid),
        .din_ready  (dinReady[1]),
        .sout       (sout[1]),
        .sout_valid (soutValid[1]),
        .frame_start(frameStart[1]),
        .busy       (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int lane, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s lane%0d cycle %0d: got %b expected %b", name, lane, edgeCnt, act, exp);
        end
    endtask

    // Reference model on the rising edge, monitor on the falling edge.
    always begin
        @(posedge clk);
        edgeCnt++;
        for (int l = 0; l < 2; l++) begin
            if (clr) begin
                expQ[l].delete();
                freeAt[l] = edgeCnt;
                lastT[l]  = -1000;
            end else if (dinValid && (edgeCnt - 1 >= freeAt[l])) begin
                for (int i = 0; i < WIDTH; i++) begin
                    int idx;
                    idx = (LANE_MSB[l] != 0) ? (WIDTH - 1 - i) : i;
                    expQ[l].push_back({din[idx], (i == 0) ? 1'b1 : 1'b0});
                end
`ifdef PISO_SERIALIZER_PARITY_EN
                expQ[l].push_back({^din, 1'b0});
`endif
                freeAt[l] = edgeCnt + FRAME + LANE_GAP[l];
                lastT[l]  = edgeCnt;
            end
        end
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            logic expIdle;
            logic expValid;
            bit [1:0] entry;
            expIdle  = (edgeCnt >= freeAt[l]);
            expValid = (edgeCnt >= lastT[l]) && (edgeCnt < lastT[l] + FRAME);
            checkOutput("din_ready", l, dinReady[l], expIdle && !clr);
            checkOutput("busy", l, busy[l], !expIdle);
            checkOutput("sout_valid", l, soutValid[l], expValid);
            if (soutValid[l] === 1'b1) begin
                if (expQ[l].size() == 0) begin
                    checkOutput("unexpected_bit", l, 1'b1, 1'b0);
                end else begin
                    entry = expQ[l].pop_front();
                    checkOutput("sout", l, sout[l], entry[1]);
                    checkOutput("frame_start", l, frameStart[l], entry[0]);
                end
            end else begin
                checkOutput("sout_idle", l, sout[l], 1'b0);
                checkOutput("frame_start_idle", l, frameStart[l], 1'b0);
            end
        end
    end

    task automatic applyStimulus(input logic c, input logic v, input logic [WIDTH-1:0] d, input int n);
        clr      = c;
        dinValid = v;
        din      = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        freeAt = '{0, 0};
        lastT  = '{-1000, -1000};
        // Reset held with a valid word present: nothing may be captured.
        applyStimulus(1'b1, 1'b1, 4'b1111, 2);
        applyStimulus(1'b0, 1'b0, 4'b0000, 2);
        // Single word.
        applyStimulus(1'b0, 1'b1, 4'b1011, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 10);
        // Streaming with valid held high.
        applyStimulus(1'b0, 1'b1, 4'b0011, 6);
        applyStimulus(1'b0, 1'b1, 4'b1100, 6);
        applyStimulus(1'b0, 1'b0, 4'b0000, 10);
        // Word offered during SHIFT must be ignored.
        applyStimulus(1'b0, 1'b1, 4'b0000, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1);
        applyStimulus(1'b0, 1'b1, 4'b1111, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 10);
        // Abort mid-frame, then a clean frame.
        applyStimulus(1'b0, 1'b1, 4'b1010, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1);
        applyStimulus(1'b1, 1'b0, 4'b0000, 1);
        applyStimulus(1'b0, 1'b1, 4'b0110, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 10);
        // Parity-oriented words (plain data frames when parity is off).
        applyStimulus(1'b0, 1'b1, 4'b1001, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 10);
        // Randomized traffic with occasional resets.
        repeat (3000) begin
            applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 4'($urandom), 1);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
